// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds the dm_ctrl access codes, MMIO register offsets and the lane merge helper.
package dmem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / 8;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  localparam logic [3:0] MMIO_LED    = 4'h0;
  localparam logic [3:0] MMIO_SW     = 4'h4;
  localparam logic [3:0] MMIO_TIMER  = 4'h8;
  localparam logic [3:0] MMIO_STATUS = 4'hC;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  typedef struct packed {
    logic         sign_ext;
    access_size_e size;
  } access_t;

  // Codes 101-111 fall through to a plain word access.
  function automatic access_t decode_ctrl(input logic [2:0] ctrl);
    access_t a;
    a.sign_ext = 1'b0;
    a.size     = SZ_WORD;
    case (ctrl)
      dm_halfword: begin
        a.sign_ext = 1'b1;
        a.size     = SZ_HALF;
      end
      dm_halfword_unsigned: a.size = SZ_HALF;
      dm_byte: begin
        a.sign_ext = 1'b1;
        a.size     = SZ_BYTE;
      end
      dm_byte_unsigned: a.size = SZ_BYTE;
      default: a.size = SZ_WORD;
    endcase
    return a;
  endfunction

  function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] cur,
                                                    input logic [WORD_W-1:0] upd,
                                                    input logic [LANES-1:0]  be);
    logic [WORD_W-1:0] r;
    r = cur;
    for (int i = 0; i < int'(LANES); i++) begin
      if (be[i]) r[8*i +: 8] = upd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Sub-word lane steering shared by the RAM and MMIO paths.
// Produces byte enables, lane-replicated store data, extended load data and the misalign flag.
module dm_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]        offset,
  input  logic [2:0]        dm_ctrl,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] read_word,
  output logic [LANES-1:0]  be_c,
  output logic [WORD_W-1:0] wdata_c,
  output logic [WORD_W-1:0] load_data_c,
  output logic              misalign_c
);

  access_t           acc;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    acc         = decode_ctrl(dm_ctrl);
    be_c        = '0;
    wdata_c     = store_data;
    load_data_c = '0;
    misalign_c  = 1'b0;
    shifted     = read_word >> {offset, 3'b000};

    case (acc.size)
      SZ_BYTE: begin
        be_c        = 4'b0001 << offset;
        wdata_c     = {4{store_data[7:0]}};
        load_data_c = {{24{acc.sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign_c  = offset[0];
        be_c        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_c     = {2{store_data[15:0]}};
        load_data_c = {{16{acc.sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misalign_c  = |offset;
        be_c        = 4'b1111;
        load_data_c = read_word;
      end
    endcase

    // A misaligned access neither writes nor returns data.
    if (misalign_c) begin
      be_c        = '0;
      load_data_c = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: word RAM plus a 16-byte MMIO window (LED, switches, timer, status).
// Loads are combinational from the address; stores commit on the rising edge.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] Data_out,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] ram [DEPTH_WORDS];

  logic [AW-1:0]     word_idx;
  logic              is_mmio;
  logic [3:0]        reg_off;
  logic [WORD_W-1:0] rd_word;

  logic [LANES-1:0]  be_c;
  logic [WORD_W-1:0] wlane_c;
  logic              misalign_c;

  logic              store_ok;
  logic              ram_we;
  logic              mmio_we;

  logic [15:0]       sw_meta;
  logic [15:0]       sw_sync;
  logic [WORD_W-1:0] timer;
  logic [WORD_W-1:0] timer_merged;
  logic [15:0]       led_merged;

  assign is_mmio  = (Addr_in[31:4] == MMIO_BASE[31:4]);
  assign word_idx = Addr_in[AW+1:2];
  assign reg_off  = {Addr_in[3:2], 2'b00};

  assign store_ok = mem_w & ~misalign_c;
  assign ram_we   = store_ok & ~is_mmio;
  assign mmio_we  = store_ok & is_mmio;

  // Word read mux; registers read their reset values while reset is held.
  always_comb begin
    rd_word = ram[word_idx];
    if (is_mmio) begin
      case (reg_off)
        MMIO_LED:    rd_word = {16'b0, led};
        MMIO_SW:     rd_word = {16'b0, sw_sync};
        MMIO_TIMER:  rd_word = timer;
        MMIO_STATUS: rd_word = {31'b0, misalign_err};
        default:     rd_word = '0;
      endcase
    end
  end

  dm_lane_align u_lane (
    .offset      (Addr_in[1:0]),
    .dm_ctrl     (dm_ctrl),
    .store_data  (Data_in),
    .read_word   (rd_word),
    .be_c        (be_c),
    .wdata_c     (wlane_c),
    .load_data_c (Data_out),
    .misalign_c  (misalign_c)
  );

  // Only lanes 0-1 exist in the LED register; upper enables are dropped.
  always_comb begin
    timer_merged = merge_lanes(timer, wlane_c, be_c);
    led_merged   = led;
    if (be_c[0]) led_merged[7:0]  = wlane_c[7:0];
    if (be_c[1]) led_merged[15:8] = wlane_c[15:8];
  end

  // RAM is not reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be_c[i]) ram[word_idx][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else if (mmio_we && reg_off == MMIO_LED) begin
      led <= led_merged;
    end
  end

  // A timer store replaces that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (mmio_we && reg_off == MMIO_TIMER) begin
      timer <= timer_merged;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // Setting on a misaligned access takes priority over an aligned-store clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (misalign_c) begin
      misalign_err <= 1'b1;
    end else if (store_ok) begin
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against Data_out, led and misalign_err.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  dm_ctrl;
  logic [31:0] Data_out;
  logic [15:0] sw;
  logic [15:0] led;
  logic        misalign_err;

  dmem_responder #(.DEPTH_WORDS(256), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_w        (mem_w),
    .Addr_in      (Addr_in),
    .Data_in      (Data_in),
    .dm_ctrl      (dm_ctrl),
    .Data_out     (Data_out),
    .sw           (sw),
    .led          (led),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DOUT, K_LED, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic probe;
  int   checks = 0;
  int   passes = 0;

  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: every probed cycle, drain the expectations queued for it.
  always @(negedge clk) begin
    if (probe) begin
      while (sb.size() != 0) begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          K_DOUT:  mon_act = Data_out;
          K_LED:   mon_act = {16'b0, led};
          default: mon_act = {31'b0, misalign_err};
        endcase
        checks++;
        if (mon_act === mon_e.exp) passes++;
        else $display("FAIL %s: got %08h expected %08h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
    probe = 1'b1;
  endtask

  task automatic exp_dout(input logic [31:0] v, input string n);
    push(K_DOUT, v, n);
  endtask

  task automatic exp_led(input logic [15:0] v, input string n);
    push(K_LED, {16'b0, v}, n);
  endtask

  task automatic exp_err(input logic v, input string n);
    push(K_ERR, {31'b0, v}, n);
  endtask

  // Advance one cycle and return the bus to an aligned idle load of word 0.
  task automatic step();
    @(posedge clk);
    #1;
    probe   = 1'b0;
    mem_w   = 1'b0;
    Addr_in = 32'h0;
    Data_in = 32'h0;
    dm_ctrl = dm_word;
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] c);
    mem_w   = 1'b0;
    Addr_in = a;
    dm_ctrl = c;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    mem_w   = 1'b1;
    Addr_in = a;
    Data_in = d;
    dm_ctrl = c;
  endtask

  initial begin
    reset = 1'b1; mem_w = 1'b0; Addr_in = '0; Data_in = '0;
    dm_ctrl = dm_word; sw = '0; probe = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(); rd(MB, dm_word); exp_dout(32'h0, "rst_led_rd");
    exp_led(16'h0, "rst_led"); exp_err(1'b0, "rst_err");
    step(); rd(MB + 32'h8, dm_word); exp_dout(32'h0, "rst_timer");
    step(); rd(MB + 32'hC, dm_word); exp_dout(32'h0, "rst_status");
    step(); rd(MB + 32'h4, dm_word); exp_dout(32'h0, "rst_sw");

    // Timer count from release, then store and wrap
    step(); reset = 1'b0; rd(MB + 32'h8, dm_word); exp_dout(32'd0, "timer_c1");
    step(); step(); step();
    step(); rd(MB + 32'h8, dm_word); exp_dout(32'd4, "timer_c5");
    step(); wr(MB + 32'h8, 32'hFFFF_FFFF, dm_word);
    step(); rd(MB + 32'h8, dm_word); exp_dout(32'hFFFF_FFFF, "timer_loaded");
    step(); rd(MB + 32'h8, dm_word); exp_dout(32'h0, "timer_wrap");

    // Store then load with extension
    step(); wr(32'h10, 32'h8081_82F3, dm_word);
    step(); rd(32'h13, dm_byte);              exp_dout(32'hFFFF_FF80, "lb_13");
    step(); rd(32'h13, dm_byte_unsigned);     exp_dout(32'h0000_0080, "lbu_13");
    step(); rd(32'h12, dm_halfword);          exp_dout(32'hFFFF_8081, "lh_12");
    step(); rd(32'h10, dm_halfword_unsigned); exp_dout(32'h0000_82F3, "lhu_10");
    step(); rd(32'h10, dm_word);              exp_dout(32'h8081_82F3, "lw_10");

    // Lane merges and read-before-write
    step(); wr(32'h10, 32'h1122_3344, dm_word); exp_dout(32'h8081_82F3, "rbw_10");
    step(); wr(32'h12, 32'hDEAD_BEEF, dm_halfword);
    step(); rd(32'h10, dm_word); exp_dout(32'hBEEF_3344, "sh_merge");
    step(); wr(32'h11, 32'h1234_56AA, dm_byte);
    step(); rd(32'h10, dm_word); exp_dout(32'hBEEF_AA44, "sb_merge");
    step(); rd(32'h410, dm_word); exp_dout(32'hBEEF_AA44, "ram_alias");
    step(); rd(32'h10, 3'b111);   exp_dout(32'hBEEF_AA44, "ctrl7_word");

    // Misalignment
    step(); wr(32'h20, 32'hCAFE_F00D, dm_word);
    step(); wr(32'h21, 32'h5555_5555, dm_word);
    exp_dout(32'h0, "mis_store_rd"); exp_err(1'b0, "err_not_yet");
    step(); rd(32'h20, dm_word); exp_dout(32'hCAFE_F00D, "mis_store_supp");
    exp_err(1'b1, "err_set_store");
    step(); rd(MB + 32'hC, dm_word); exp_dout(32'h1, "status_1");
    step(); wr(MB + 32'hC, 32'h0, dm_word);
    step(); rd(MB + 32'hC, dm_word); exp_dout(32'h0, "status_clr");
    exp_err(1'b0, "err_clr");
    step(); rd(32'h23, dm_halfword); exp_dout(32'h0, "mis_load_zero");
    step(); exp_err(1'b1, "err_set_load");
    step(); wr(MB + 32'hC, 32'h0, dm_word);
    step(); wr(MB + 32'hD, 32'h0, dm_halfword); exp_err(1'b0, "err_clr2");
    step(); rd(MB + 32'hC, dm_word); exp_dout(32'h1, "status_mis_st");
    exp_err(1'b1, "err_mis_status");

    // LED register
    step(); wr(MB, 32'h1234_A5A5, dm_word);
    step(); rd(MB, dm_word); exp_dout(32'h0000_A5A5, "led_rd");
    exp_led(16'hA5A5, "led_out");
    step(); wr(MB + 32'h2, 32'h77, dm_byte);
    step(); wr(MB + 32'h1, 32'h3C, dm_byte); exp_led(16'hA5A5, "led_lane2_ign");
    step(); rd(MB, dm_word); exp_dout(32'h0000_3CA5, "led_byte_rd");
    exp_led(16'h3CA5, "led_byte");
    step(); rd(MB + 32'h1, dm_byte_unsigned); exp_dout(32'h3C, "led_lbu");

    // Switch synchronizer
    step(); sw = 16'h00F0; rd(MB + 32'h4, dm_word); exp_dout(32'h0, "sw_e0");
    step(); rd(MB + 32'h4, dm_word); exp_dout(32'h0, "sw_e1");
    step(); rd(MB + 32'h4, dm_word); exp_dout(32'h00F0, "sw_e2");
    step(); wr(MB + 32'h4, 32'hFFFF, dm_word);
    step(); rd(MB + 32'h4, dm_word); exp_dout(32'h00F0, "sw_ro");
    exp_led(16'h3CA5, "sw_wr_no_led");

    // Asynchronous reset in the middle of a store
    step(); wr(MB, 32'hFFFF, dm_word);
    step(); rd(32'h23, dm_halfword); exp_led(16'hFFFF, "led_ffff");
    step(); exp_err(1'b1, "err_pre_rst");
    step(); reset = 1'b1; wr(MB, 32'h1111, dm_word);
    exp_led(16'h0, "rst_async_led"); exp_err(1'b0, "rst_async_err");
    exp_dout(32'h0, "rst_async_rd");
    step(); wr(MB, 32'h2222, dm_word); exp_led(16'h0, "rst_held_led");
    step(); reset = 1'b0; rd(32'h20, dm_word); exp_dout(32'hCAFE_F00D, "ram_keep_20");
    step(); rd(32'h10, dm_word); exp_dout(32'hBEEF_AA44, "ram_keep_10");
    step();
    step();

    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL sb_drain: got %0d expected 0 pending", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
